// File: rtl/mem_arbiter.sv
// Byte-serial RAM sequencer shared by instruction fetch and the MEM stage; loads/stores win over fetch.
// Reads finish N+1 cycles after acceptance and writes N cycles after it. I/O writes stall while the I/O buffer is full.
module mem_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_jump_flag,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_done,
    output logic [31:0]       o_if_inst,
    input  logic              i_mem_req,
    input  logic              i_mem_we,
    input  logic [1:0]        i_mem_len,
    input  logic              i_mem_signed,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [31:0]       i_mem_wdata,
    output logic              o_mem_done,
    output logic [31:0]       o_mem_rdata,
    input  logic              i_io_buffer_full,
    output logic [ADDR_W-1:0] o_ram_a,
    output logic [7:0]        o_ram_dout,
    output logic              o_ram_wr,
    input  logic [7:0]        i_ram_din
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [2:0]        r_n;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic              r_signed;
    logic [31:0]       r_buf;
    logic              r_if_done;
    logic              r_mem_done;
    logic [31:0]       r_if_inst;
    logic [31:0]       r_mem_rdata;

    logic [ADDR_W-1:0] w_addr;
    logic              w_rd;
    logic              w_io_stall;
    logic [7:0]        w_wbyte;
    logic [31:0]       w_asm;
    logic [31:0]       w_ext;
    logic [2:0]        w_mem_n;

    assign w_addr     = r_base + ADDR_W'(r_cnt);
    assign w_rd       = (r_state == IF_RD) || (r_state == MEM_RD);
    assign w_io_stall = (r_state == MEM_WR) && (r_base[17:16] == IO_HI) && i_io_buffer_full;
    assign w_mem_n    = (i_mem_len == 2'b00) ? 3'd1 : (i_mem_len == 2'b01) ? 3'd2 : 3'd4;

    always_comb begin
        w_wbyte = r_wdata[7:0];
        case (r_cnt[1:0])
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            2'd3:    w_wbyte = r_wdata[31:24];
            default: w_wbyte = r_wdata[7:0];
        endcase
    end

    // The byte addressed in the previous cycle arrives now and lands in slot cnt-1.
    always_comb begin
        w_asm = r_buf;
        case (r_cnt)
            3'd1:    w_asm[7:0]   = i_ram_din;
            3'd2:    w_asm[15:8]  = i_ram_din;
            3'd3:    w_asm[23:16] = i_ram_din;
            3'd4:    w_asm[31:24] = i_ram_din;
            default: w_asm = r_buf;
        endcase
    end

    always_comb begin
        case (r_n)
            3'd1:    w_ext = {{24{r_signed & w_asm[7]}}, w_asm[7:0]};
            3'd2:    w_ext = {{16{r_signed & w_asm[15]}}, w_asm[15:0]};
            default: w_ext = w_asm;
        endcase
    end

    // The RAM port is combinational from state so the I/O stall can gate the write in the same cycle.
    always_comb begin
        o_ram_a    = '0;
        o_ram_dout = '0;
        o_ram_wr   = 1'b0;
        if (w_rd && (r_cnt < r_n)) begin
            o_ram_a = w_addr;
        end else if (r_state == MEM_WR) begin
            o_ram_a    = w_addr;
            o_ram_dout = w_wbyte;
            o_ram_wr   = !w_io_stall;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_n         <= 3'd0;
            r_base      <= '0;
            r_wdata     <= 32'd0;
            r_signed    <= 1'b0;
            r_buf       <= 32'd0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_inst   <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_mem_req && !r_mem_done) begin
                        r_base   <= i_mem_addr;
                        r_n      <= w_mem_n;
                        r_wdata  <= i_mem_wdata;
                        r_signed <= i_mem_signed;
                        r_cnt    <= 3'd0;
                        r_state  <= i_mem_we ? MEM_WR : MEM_RD;
                    end else if (i_if_req && !r_if_done && !i_jump_flag) begin
                        r_base   <= i_if_addr;
                        r_n      <= 3'd4;
                        r_signed <= 1'b0;
                        r_cnt    <= 3'd0;
                        r_state  <= IF_RD;
                    end
                end
                IF_RD: begin
                    if (i_jump_flag) begin
                        r_state <= IDLE;
                        r_cnt   <= 3'd0;
                    end else begin
                        r_buf <= w_asm;
                        if (r_cnt == r_n) begin
                            r_state   <= IDLE;
                            r_cnt     <= 3'd0;
                            r_if_done <= 1'b1;
                            r_if_inst <= w_asm;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                MEM_RD: begin
                    r_buf <= w_asm;
                    if (r_cnt == r_n) begin
                        r_state     <= IDLE;
                        r_cnt       <= 3'd0;
                        r_mem_done  <= 1'b1;
                        r_mem_rdata <= w_ext;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                MEM_WR: begin
                    if (!w_io_stall) begin
                        if (r_cnt == r_n - 3'd1) begin
                            r_state    <= IDLE;
                            r_cnt      <= 3'd0;
                            r_mem_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_if_done   = r_if_done;
    assign o_if_inst   = r_if_inst;
    assign o_mem_done  = r_mem_done;
    assign o_mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked against a byte-array memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_jump_flag;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_done;
    logic [31:0] o_if_inst;
    logic        i_mem_req;
    logic        i_mem_we;
    logic [1:0]  i_mem_len;
    logic        i_mem_signed;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic        o_mem_done;
    logic [31:0] o_mem_rdata;
    logic        i_io_buffer_full;
    logic [31:0] o_ram_a;
    logic [7:0]  o_ram_dout;
    logic        o_ram_wr;
    logic [7:0]  i_ram_din = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  ram  [logic [31:0]];
    logic [7:0]  gold [logic [31:0]];
    logic [31:0] wlog_a[$];
    logic [7:0]  wlog_d[$];
    logic [31:0] tr_a[$];
    logic        tr_w[$];
    logic [7:0]  tr_d[$];
    logic [31:0] exp_inst = 32'd0;

    mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .i_jump_flag(i_jump_flag),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_done(o_if_done), .o_if_inst(o_if_inst),
        .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_len(i_mem_len), .i_mem_signed(i_mem_signed),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .o_mem_done(o_mem_done), .o_mem_rdata(o_mem_rdata),
        .i_io_buffer_full(i_io_buffer_full), .o_ram_a(o_ram_a), .o_ram_dout(o_ram_dout),
        .o_ram_wr(o_ram_wr), .i_ram_din(i_ram_din)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data for the address seen at an edge is presented after that edge.
    always @(posedge clk) begin
        if (o_ram_wr) begin
            ram[o_ram_a] = o_ram_dout;
            wlog_a.push_back(o_ram_a);
            wlog_d.push_back(o_ram_dout);
        end
        i_ram_din <= ram.exists(o_ram_a) ? ram[o_ram_a] : 8'h00;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    function automatic int len_bytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [7:0] gold_rd(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : 8'h00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n, input bit sgn);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(gold_rd(a + 32'(i))) << (8 * i));
        if (sgn && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a]  = d;
        gold[a] = d;
    endtask

    task automatic idle_inputs();
        i_jump_flag = 0; i_if_req = 0; i_if_addr = 0; i_mem_req = 0; i_mem_we = 0;
        i_mem_len = 0; i_mem_signed = 0; i_mem_addr = 0; i_mem_wdata = 0; i_io_buffer_full = 0;
    endtask

    // Drives one request and waits for its done pulse; lat is the negedge index of the pulse, -1 on timeout.
    task automatic run_txn(input bit is_fetch, input bit we, input logic [1:0] len, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                           input bit jmp_noise, output logic [31:0] got, output int lat);
        bit done;
        done = 0; lat = -1; got = 32'd0;
        tr_a.delete(); tr_w.delete(); tr_d.delete(); wlog_a.delete(); wlog_d.delete();
        @(posedge clk); #1;
        if (is_fetch) begin
            i_if_req = 1; i_if_addr = addr;
        end else begin
            i_mem_req = 1; i_mem_we = we; i_mem_len = len; i_mem_signed = sgn;
            i_mem_addr = addr; i_mem_wdata = wdata;
        end
        i_io_buffer_full = (stall > 0);
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            tr_a.push_back(o_ram_a); tr_w.push_back(o_ram_wr); tr_d.push_back(o_ram_dout);
            if (is_fetch ? o_if_done : o_mem_done) begin
                done = 1; lat = k;
                got = is_fetch ? o_if_inst : o_mem_rdata;
            end
            @(posedge clk); #1;
            if (k == stall + 1) i_io_buffer_full = 0;
            if (jmp_noise) i_jump_flag = 1'($urandom_range(0, 1));
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (o_if_done !== 1'b0) begin n_fail++; $display("FAIL reset_if_done: got %b want 0", o_if_done); end
        n_checks++; if (o_mem_done !== 1'b0) begin n_fail++; $display("FAIL reset_mem_done: got %b want 0", o_mem_done); end
        n_checks++; if (o_if_inst !== 32'd0) begin n_fail++; $display("FAIL reset_if_inst: got %h want 0", o_if_inst); end
        n_checks++; if (o_mem_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_rdata: got %h want 0", o_mem_rdata); end
        n_checks++; if ({o_ram_wr, o_ram_a, o_ram_dout} !== 41'd0) begin
            n_fail++; $display("FAIL reset_ram_port: got wr=%b a=%h d=%h want all 0", o_ram_wr, o_ram_a, o_ram_dout);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_word_fetch();
        logic [31:0] got;
        int lat;
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        run_txn(1, 0, 2'b10, 0, 32'h100, 0, 0, 0, got, lat);
        exp_inst = 32'h0000_0513;
        n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL fetch_latency: got %0d want 7", lat); end
        n_checks++; if (got !== exp_inst) begin n_fail++; $display("FAIL fetch_inst: got %h want %h", got, exp_inst); end
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (tr_a.size() > c + 1 && tr_a[c + 1] !== 32'h100 + 32'(c)) begin
                n_fail++; $display("FAIL fetch_addr_step%0d: got %h want %h", c, tr_a[c + 1], 32'h100 + 32'(c));
            end else if (tr_a.size() <= c + 1) begin
                n_fail++; $display("FAIL fetch_addr_step%0d: got no sample want %h", c, 32'h100 + 32'(c));
            end
        end
        n_checks++; if (tr_a.size() >= 6 && tr_a[5] !== 32'd0) begin n_fail++; $display("FAIL fetch_capture_addr: got %h want 0", tr_a[5]); end
        @(negedge clk);
        n_checks++; if (o_if_done !== 1'b0) begin n_fail++; $display("FAIL fetch_single_pulse: got %b want 0", o_if_done); end
        n_checks++; if (o_if_inst !== exp_inst) begin n_fail++; $display("FAIL fetch_inst_hold: got %h want %h", o_if_inst, exp_inst); end
    endtask

    task automatic test_signed_load();
        logic [31:0] got;
        int lat;
        poke(32'h204, 8'h80);
        run_txn(0, 0, 2'b00, 1, 32'h204, 0, 0, 0, got, lat);
        n_checks++; if (got !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_signed: got %h want FFFFFF80", got); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL lb_latency: got %0d want 4", lat); end
        run_txn(0, 0, 2'b00, 0, 32'h204, 0, 0, 0, got, lat);
        n_checks++; if (got !== 32'h0000_0080) begin n_fail++; $display("FAIL lb_unsigned: got %h want 00000080", got); end
    endtask

    task automatic test_conflict();
        int md, id;
        logic [31:0] got, want;
        md = 0; id = 0; got = 0;
        poke(32'h0, 8'hA1); poke(32'h1, 8'hB2); poke(32'h2, 8'hC3); poke(32'h3, 8'hD4);
        wlog_a.delete(); wlog_d.delete();
        @(posedge clk); #1;
        i_if_req = 1; i_if_addr = 32'h0;
        i_mem_req = 1; i_mem_we = 1; i_mem_len = 2'b01; i_mem_addr = 32'h10; i_mem_wdata = 32'h0000_1234;
        for (int k = 1; k <= 30 && id == 0; k++) begin
            @(negedge clk);
            if (o_mem_done && md == 0) md = k;
            if (o_if_done) begin id = k; got = o_if_inst; end
            @(posedge clk); #1;
            if (md == k) i_mem_req = 0;
            if (id == k) i_if_req = 0;
        end
        idle_inputs();
        gold[32'h10] = 8'h34; gold[32'h11] = 8'h12;
        want = model_read(32'h0, 4, 0);
        exp_inst = want;
        n_checks++; if (md !== 3 + 1) begin n_fail++; $display("FAIL conflict_store_first: got done at %0d want 4", md); end
        n_checks++; if (id !== md + 6) begin n_fail++; $display("FAIL conflict_fetch_after: got done at %0d want %0d", id, md + 6); end
        n_checks++; if (got !== want) begin n_fail++; $display("FAIL conflict_fetch_data: got %h want %h", got, want); end
        n_checks++;
        if (wlog_a.size() != 2 || wlog_a[0] !== 32'h10 || wlog_d[0] !== 8'h34 || wlog_a[1] !== 32'h11 || wlog_d[1] !== 8'h12) begin
            n_fail++; $display("FAIL conflict_writes: got %0d writes first a=%h d=%h want 10<-34 11<-12",
                               wlog_a.size(), wlog_a.size() > 0 ? wlog_a[0] : 32'hx, wlog_d.size() > 0 ? wlog_d[0] : 8'hx);
        end
    endtask

    task automatic test_flush();
        int seen_done, seen_wr;
        logic [31:0] a_cnt2, a_after, got;
        int lat;
        seen_done = 0; seen_wr = 0; a_cnt2 = 0; a_after = 0;
        for (int i = 0; i < 4; i++) begin
            poke(32'h200 + 32'(i), 8'($urandom));
            poke(32'h40 + 32'(i), 8'($urandom));
        end
        @(posedge clk); #1;
        i_if_req = 1; i_if_addr = 32'h200;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (o_if_done) seen_done++;
            if (o_ram_wr) seen_wr++;
            if (k == 4) a_cnt2 = o_ram_a;
            if (k == 5) a_after = o_ram_a;
            @(posedge clk); #1;
            if (k == 3) i_jump_flag = 1;
            if (k == 4) begin i_jump_flag = 0; i_if_req = 0; end
        end
        n_checks++; if (a_cnt2 !== 32'h202) begin n_fail++; $display("FAIL flush_cnt2_addr: got %h want 202", a_cnt2); end
        n_checks++; if (a_after !== 32'd0) begin n_fail++; $display("FAIL flush_idle_addr: got %h want 0", a_after); end
        n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", seen_done); end
        n_checks++; if (seen_wr !== 0) begin n_fail++; $display("FAIL flush_no_write: got %0d writes want 0", seen_wr); end
        n_checks++; if (o_if_inst !== exp_inst) begin n_fail++; $display("FAIL flush_inst_kept: got %h want %h", o_if_inst, exp_inst); end
        run_txn(1, 0, 2'b10, 0, 32'h40, 0, 0, 0, got, lat);
        exp_inst = model_read(32'h40, 4, 0);
        n_checks++; if (got !== exp_inst || lat !== 7) begin
            n_fail++; $display("FAIL refetch: got %h at %0d want %h at 7", got, lat, exp_inst);
        end
    endtask

    task automatic test_io_stall();
        logic [31:0] got;
        int lat;
        run_txn(0, 1, 2'b00, 0, 32'h0003_0000, 32'h41, 3, 0, got, lat);
        gold[32'h0003_0000] = 8'h41;
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL io_latency: got %0d want 6", lat); end
        n_checks++; if (tr_w.size() < 5 || tr_w[1] !== 0 || tr_w[2] !== 0 || tr_w[3] !== 0) begin
            n_fail++; $display("FAIL io_stall_wr: got %0d samples, wr during stall not all 0, want 0 0 0", tr_w.size());
        end
        n_checks++; if (wlog_a.size() != 1 || wlog_a[0] !== 32'h0003_0000 || wlog_d[0] !== 8'h41) begin
            n_fail++; $display("FAIL io_write: got %0d writes want one 30000<-41", wlog_a.size());
        end
        n_checks++; if (tr_w.size() >= 5 && (tr_w[4] !== 1'b1 || tr_d[4] !== 8'h41)) begin
            n_fail++; $display("FAIL io_resume: got wr=%b d=%h want wr=1 d=41", tr_w[4], tr_d[4]);
        end
    endtask

    task automatic test_random();
        logic [31:0] got, addr, wdata, want;
        logic [1:0] len;
        int lat, kind, stall, n, exp_lat, region;
        bit sgn, io;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            region = $urandom_range(0, 2);
            addr = (region == 0) ? 32'h1000 + 32'($urandom_range(0, 63)) :
                   (region == 1) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) :
                                   32'h0003_0100 + 32'($urandom_range(0, 15));
            len = 2'($urandom_range(0, 3));
            sgn = 1'($urandom_range(0, 1));
            wdata = $urandom;
            stall = (kind == 2) ? $urandom_range(0, 3) : 0;
            n = (kind == 0) ? 4 : len_bytes(len);
            io = (addr[17:16] == 2'b11);
            if (kind == 0) begin
                run_txn(1, 0, 2'b10, 0, addr, 0, 0, 0, got, lat);
                want = model_read(addr, 4, 0);
                exp_lat = n + 3;
            end else if (kind == 1) begin
                run_txn(0, 0, len, sgn, addr, 0, 0, 1, got, lat);
                want = model_read(addr, n, sgn);
                exp_lat = n + 3;
            end else begin
                run_txn(0, 1, len, sgn, addr, wdata, stall, 1, got, lat);
                want = got;
                exp_lat = n + 2 + (io ? stall : 0);
                n_checks++;
                if (wlog_a.size() != n) begin
                    n_fail++; $display("FAIL rnd%0d_write_count: got %0d want %0d", t, wlog_a.size(), n);
                end else begin
                    for (int i = 0; i < n; i++) begin
                        if (wlog_a[i] !== addr + 32'(i) || wlog_d[i] !== 8'(wdata >> (8 * i))) begin
                            n_fail++; $display("FAIL rnd%0d_write_byte%0d: got %h<-%h want %h<-%h", t, i,
                                               wlog_a[i], wlog_d[i], addr + 32'(i), 8'(wdata >> (8 * i)));
                            break;
                        end
                    end
                end
                for (int i = 0; i < n; i++) gold[addr + 32'(i)] = 8'(wdata >> (8 * i));
            end
            n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency: kind %0d got %0d want %0d", t, kind, lat, exp_lat); end
            n_checks++; if (got !== want) begin n_fail++; $display("FAIL rnd%0d_data: kind %0d got %h want %h", t, kind, got, want); end
        end
    endtask

    task automatic test_reset_mid();
        logic        wr_cnt1;
        logic [31:0] a_cnt1;
        int seen_done;
        seen_done = 0; wr_cnt1 = 0; a_cnt1 = 0;
        @(posedge clk); #1;
        i_mem_req = 1; i_mem_we = 1; i_mem_len = 2'b10; i_mem_addr = 32'h500; i_mem_wdata = 32'hAABB_CCDD;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 3) begin wr_cnt1 = o_ram_wr; a_cnt1 = o_ram_a; end
            @(posedge clk); #1;
            if (k == 2) rst = 1;
        end
        @(negedge clk);
        n_checks++; if (wr_cnt1 !== 1'b1 || a_cnt1 !== 32'h501) begin
            n_fail++; $display("FAIL rstmid_cnt1: got wr=%b a=%h want wr=1 a=501", wr_cnt1, a_cnt1);
        end
        n_checks++;
        if ({o_ram_wr, o_ram_a, o_ram_dout, o_if_done, o_mem_done, o_if_inst, o_mem_rdata} !== 107'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got wr=%b a=%h d=%h ifd=%b md=%b inst=%h rd=%h want all 0",
                               o_ram_wr, o_ram_a, o_ram_dout, o_if_done, o_mem_done, o_if_inst, o_mem_rdata);
        end
        @(posedge clk); #1;
        rst = 0; idle_inputs();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_mem_done) seen_done++;
        end
        n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen_done); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_word_fetch();
        test_signed_load();
        test_conflict();
        test_flush();
        test_io_stall();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
